// File: rtl/gc_pkg.sv
// Shared Gray-code helpers and monitor FSM encoding.
// Used by the Gray counter, its monitor and the bench.
package gc_pkg;

  localparam int GC_WIDTH = 8;
  localparam int GC_MAX_W = 32;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } gc_state_t;

  // Zero-extended Gray input yields a zero-extended binary result.
  function automatic logic [GC_MAX_W-1:0] gray2bin(
    input logic [GC_MAX_W-1:0] g
  );
    logic [GC_MAX_W-1:0] b;
    b[GC_MAX_W-1] = g[GC_MAX_W-1];
    for (int i = GC_MAX_W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [GC_MAX_W-1:0] bin2gray(
    input logic [GC_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gc_sync2.sv
// Two-flop synchroniser for a bus whose bits change
// one at a time (Gray coded), so skew cannot tear it.
module gc_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // Two register stages into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/gc_monitor.sv
// Checks a Gray counter bus for single forward steps,
// counting steps, wraps and errors, with a fault latch.
module gc_monitor
  import gc_pkg::*;
#(
  parameter int WIDTH     = GC_WIDTH,
  parameter int CNT_W     = 16,
  parameter int ERR_W     = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clear,
  output logic [WIDTH-1:0] bin_out,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             step_pulse,
  output logic             wrap_pulse,
  output logic             err_pulse,
  output logic             fault
);

  gc_state_t        state;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] b_cur;
  logic [WIDTH-1:0] b_prev;
  logic [WIDTH-1:0] b_next;
  logic [ERR_W-1:0] err_next;
  logic             one_bit;
  logic             is_fwd;
  logic             legal;
  logic             bad;
  logic             wrap;
  logic             hit_limit;

  gc_sync2 #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .d  (gray_in),
    .q  (s2)
  );

  // Classify the newest synchronised value against p.
  always_comb begin
    b_cur  = WIDTH'(gray2bin(GC_MAX_W'(s2)));
    b_prev = WIDTH'(gray2bin(GC_MAX_W'(p)));
    b_next = b_prev + WIDTH'(1);
    diff   = s2 ^ p;
    one_bit = ($countones(diff) == 1);
    is_fwd  = (b_cur == b_next);
    legal  = (state == TRACK) && one_bit && is_fwd;
    bad    = (state == TRACK) && (diff != '0)
             && !(one_bit && is_fwd);
    wrap   = legal && (&b_prev);
    err_next = (&err_cnt) ? err_cnt
                          : err_cnt + ERR_W'(1);
    hit_limit = (err_next == ERR_W'(ERR_LIMIT));
  end

  // FSM, saturating counters and one-cycle strobes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= INIT;
      p          <= '0;
      bin_out    <= '0;
      step_cnt   <= '0;
      wrap_cnt   <= '0;
      err_cnt    <= '0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      bin_out    <= b_cur;
      p          <= s2;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      if (clear) begin
        state    <= INIT;
        step_cnt <= '0;
        wrap_cnt <= '0;
        err_cnt  <= '0;
        fault    <= 1'b0;
      end else begin
        unique case (state)
          INIT: begin
            state <= TRACK;
          end
          TRACK: begin
            if (legal) begin
              step_pulse <= 1'b1;
              if (!(&step_cnt))
                step_cnt <= step_cnt + CNT_W'(1);
            end
            if (wrap) begin
              wrap_pulse <= 1'b1;
              if (!(&wrap_cnt))
                wrap_cnt <= wrap_cnt + CNT_W'(1);
            end
            if (bad) begin
              err_pulse <= 1'b1;
              err_cnt   <= err_next;
              if (hit_limit) begin
                state <= FAULT;
                fault <= 1'b1;
              end
            end
          end
          FAULT: begin
            fault <= 1'b1;
          end
          default: begin
            state <= INIT;
            fault <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gc_monitor.sv
// Directed-vector bench for gc_monitor.
// Expected values are worked out by hand per scenario.
module tb_gc_monitor;
  import gc_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  gray_in;
  logic        clear;
  logic [7:0]  bin_out;
  logic [15:0] step_cnt;
  logic [15:0] wrap_cnt;
  logic [7:0]  err_cnt;
  logic        step_pulse;
  logic        wrap_pulse;
  logic        err_pulse;
  logic        fault;

  int n_cmp;
  int n_bad;
  int steps_seen;
  int wraps_seen;
  int errs_seen;

  gc_monitor #(
    .WIDTH(8),
    .CNT_W(16),
    .ERR_W(8),
    .ERR_LIMIT(4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .gray_in   (gray_in),
    .clear     (clear),
    .bin_out   (bin_out),
    .step_cnt  (step_cnt),
    .wrap_cnt  (wrap_cnt),
    .err_cnt   (err_cnt),
    .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse),
    .err_pulse (err_pulse),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp_v
  );
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] g(input int b);
    return 8'(bin2gray(32'(b)));
  endfunction

  task automatic zero_seen();
    steps_seen = 0;
    wraps_seen = 0;
    errs_seen  = 0;
  endtask

  // One clock, then per-pulse checks against bench tallies.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (step_pulse) begin
      steps_seen++;
      check("step_cnt_at_pulse",
            32'(step_cnt), 32'(steps_seen));
    end
    if (wrap_pulse) begin
      wraps_seen++;
      check("wrap_with_step", 32'(step_pulse), 1);
      check("wrap_bin", 32'(bin_out), 0);
    end
    if (err_pulse) begin
      errs_seen++;
      check("err_cnt_at_pulse",
            32'(err_cnt), 32'(errs_seen));
      check("fault_at_pulse", 32'(fault),
            32'(errs_seen >= 4));
    end
  endtask

  task automatic feed(input logic [7:0] v);
    gray_in = v;
    cyc();
  endtask

  task automatic settle();
    cyc();
    cyc();
  endtask

  // Clear long enough for s2 to hold v before INIT.
  task automatic resync(input logic [7:0] v);
    gray_in = v;
    clear = 1'b1;
    repeat (3) cyc();
    clear = 1'b0;
    cyc();
    zero_seen();
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_bin"}, 32'(bin_out), 0);
    check({tag, "_step"}, 32'(step_cnt), 0);
    check({tag, "_wrap"}, 32'(wrap_cnt), 0);
    check({tag, "_err"}, 32'(err_cnt), 0);
    check({tag, "_pulses"},
          32'({step_pulse, wrap_pulse, err_pulse}), 0);
    check({tag, "_fault"}, 32'(fault), 0);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    clear   = 1'b0;
    gray_in = 8'h00;
    zero_seen();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    all_zero("rst");
    #1 rst = 1'b0;
    cyc();
    cyc();

    // Count 0..9
    for (int i = 0; i <= 9; i++) feed(g(i));
    settle();
    check("cnt_step", 32'(step_cnt), 9);
    check("cnt_err", 32'(err_cnt), 0);
    check("cnt_bin", 32'(bin_out), 9);
    check("cnt_fault", 32'(fault), 0);
    check("cnt_seen", 32'(steps_seen), 9);

    // Wrap 250..255, 0..2
    resync(g(250));
    check("clr_step", 32'(step_cnt), 0);
    for (int i = 251; i <= 258; i++) feed(g(i % 256));
    settle();
    check("wr_step", 32'(step_cnt), 8);
    check("wr_wrap", 32'(wrap_cnt), 1);
    check("wr_seen", 32'(wraps_seen), 1);
    check("wr_err", 32'(err_cnt), 0);
    check("wr_bin", 32'(bin_out), 2);

    // Two legal steps then backward and jump errors
    resync(8'h01);
    feed(8'h03);
    feed(8'h02);
    feed(8'h03);
    feed(8'h07);
    settle();
    check("er_step", 32'(step_cnt), 2);
    check("er_err", 32'(err_cnt), 2);
    check("er_seen", 32'(errs_seen), 2);
    check("er_fault", 32'(fault), 0);

    // Four illegal jumps enter FAULT
    resync(8'h00);
    feed(8'h03);
    feed(8'h00);
    feed(8'h03);
    feed(8'h00);
    settle();
    check("ft_err", 32'(err_cnt), 4);
    check("ft_fault", 32'(fault), 1);
    check("ft_seen", 32'(errs_seen), 4);
    feed(8'h01);
    feed(8'h03);
    feed(8'h02);
    settle();
    check("ft_step_frozen", 32'(step_cnt), 0);
    check("ft_steps_seen", 32'(steps_seen), 0);
    check("ft_bin_tracks", 32'(bin_out), 3);
    feed(8'h07);
    settle();
    check("ft_err_frozen", 32'(err_cnt), 4);
    check("ft_bin5", 32'(bin_out), 5);
    check("ft_still", 32'(fault), 1);
    clear = 1'b1;
    cyc();
    check("cl_fault", 32'(fault), 0);
    check("cl_err", 32'(err_cnt), 0);
    check("cl_step", 32'(step_cnt), 0);
    clear = 1'b0;
    cyc();
    check("cl_init_pulses",
          32'({step_pulse, wrap_pulse, err_pulse}), 0);
    check("cl_init_fault", 32'(fault), 0);

    // Clear coincident with a legal step
    zero_seen();
    feed(8'h05);
    feed(8'h04);
    settle();
    check("cs_pre", 32'(step_cnt), 2);
    gray_in = 8'h0C;
    cyc();
    cyc();
    clear = 1'b1;
    cyc();
    check("cs_step", 32'(step_cnt), 0);
    check("cs_pulse", 32'(step_pulse), 0);
    clear = 1'b0;
    cyc();
    cyc();
    check("cs_after_pulse", 32'(step_pulse), 0);
    check("cs_after_cnt", 32'(step_cnt), 0);

    // Async reset mid-stream
    zero_seen();
    feed(8'h0D);
    feed(8'h0F);
    settle();
    check("ar_pre", 32'(step_cnt), 2);
    gray_in = 8'h0E;
    cyc();
    #2 rst = 1'b1;
    #1;
    all_zero("ar");
    gray_in = 8'h01;
    @(posedge clk);
    #2 rst = 1'b0;
    zero_seen();
    cyc();
    check("ar_e1",
          32'({step_pulse, wrap_pulse, err_pulse}), 0);
    cyc();
    check("ar_e2",
          32'({step_pulse, wrap_pulse, err_pulse}), 0);
    check("ar_e2_bin", 32'(bin_out), 0);
    cyc();
    check("ar_e3_step", 32'(step_pulse), 1);
    check("ar_e3_cnt", 32'(step_cnt), 1);
    check("ar_e3_bin", 32'(bin_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gc_monitor.md
# gc_monitor

Downstream consumer of the 8-bit Gray-code counter output in the user project. It synchronises the Gray bus, converts it to binary and checks that every change is a legal single forward Gray step. It counts steps, wrap-arounds and errors, and latches a fault once errors reach a limit. Results go to LA/IO for the management SoC.

## Interface
- WIDTH, 8: Gray/binary bus width.
- CNT_W, 16: width of the step and wrap counters.
- ERR_W, 8: width of the error counter.
- ERR_LIMIT, 4: error count at which FAULT is entered; must be ≥1.
- wb_clk_i  in  1  sole clock; all state updates on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- gray_in  in  WIDTH  Gray code from the counter; may be asynchronous to wb_clk_i.
- clear  in  1  synchronous clear of counters, flags and FSM; returns the FSM to INIT.
- bin_out  out  WIDTH  binary value of the synchronised Gray input (registered).
- step_cnt  out  CNT_W  legal forward steps; saturates at all-ones.
- wrap_cnt  out  CNT_W  forward steps from 2^WIDTH−1 to 0; saturates.
- err_cnt  out  ERR_W  illegal transitions; saturates.
- step_pulse  out  1  one-cycle strobe per legal step.
- wrap_pulse  out  1  one-cycle strobe per wrap; coincides with step_pulse.
- err_pulse  out  1  one-cycle strobe per illegal transition.
- fault  out  1  high while the FSM is in FAULT.

## Operation
- Synchroniser: s1 <= gray_in; s2 <= s1. Both reset to 0.
- Conversion: b[W−1] = g[W−1]; b[i] = b[i+1] ^ g[i]. bin_out <= gray2bin(s2) every cycle in all states.
- Reference register p holds the previous synchronised Gray value; reset to 0.
- diff = s2 ^ p, evaluated in TRACK only:
  - popcount 0: no event.
  - popcount 1 and gray2bin(s2) == gray2bin(p)+1 mod 2^WIDTH: legal step. step_pulse is asserted. If gray2bin(p) is all-ones, wrap_pulse is also asserted.
  - any other value (backward step or more than one bit changed): err_pulse.
  - In every case p <= s2.
- FSM:
  - INIT: entered after reset or clear. One cycle long: p <= s2, no events, then go to TRACK.
  - TRACK: classification as above. Go to FAULT in the same edge that err_cnt reaches ERR_LIMIT.
  - FAULT: counters and pulses are frozen (pulses 0) and fault=1. bin_out and p keep updating. Only clear or reset exits FAULT, to INIT.
- Counters increment on their pulse and hold at all-ones. No wrap of step_cnt, wrap_cnt or err_cnt.
- clear has priority over any same-cycle event. On a clear cycle the counters go to 0, pulses are 0 and the FSM goes to INIT. p is reloaded in INIT, so no event fires on the cycle after clear.
- Reset values: bin_out=0, all counters 0, all pulses 0, fault=0, FSM=INIT.

## Timing
- gray_in stable before edge k → s2 valid after k+1 → bin_out and the pulses/counters that reflect it update at edge k+2. Latency is 2 cycles.
- Pulses last exactly one cycle. Counter values are visible in the same cycle as their pulse.
- Reset asserted mid-operation clears everything asynchronously. The first classification occurs 2 edges after release: the INIT edge, then the first TRACK edge.
- An error that brings err_cnt to ERR_LIMIT: err_pulse=1, err_cnt=ERR_LIMIT and fault=1 all appear after the same edge.
- An upstream counter held by enable=0 shows as popcount 0. It is neither counted nor an error.

## Structure
- Shared package gc_pkg: FSM state encoding (INIT=2'd0, TRACK=2'd1, FAULT=2'd2), default WIDTH, and the gray2bin / bin2gray functions. The upstream counter and bench reuse the same functions.
- Sub-module gc_sync2: parameterised WIDTH two-flop synchroniser with async active-high reset.
- Everything else lives in gc_monitor: classifier, counters and FSM.

## Test plan
- Reset, then feed Gray of 0..9 one value per cycle → step_cnt=9, err_cnt=0, bin_out=9 two cycles after the last input, fault=0.
- Feed Gray of 250..255 then 0..2 (8'h80 → 8'h00 on the wrap) → exactly one wrap_pulse, on the 255→0 step; wrap_cnt=1; step_cnt=8.
- Jump 8'h01 → 8'h07, then 8'h02 → 8'h03 (binary 3→2, backward) → err_cnt=2, step_cnt unchanged.
- Inject four illegal jumps (ERR_LIMIT=4) → fault=1 on the 4th err_pulse. Later legal steps leave step_cnt frozen while bin_out still tracks. clear → fault=0, counters 0, and no event on the following cycle.
- Assert clear in the same cycle as a legal step → step_cnt=0 and no step_pulse.
- Assert wb_rst_i asynchronously between edges mid-stream → all outputs 0 immediately. After release the first event is no earlier than 2 edges later.
